axis_fifo_wrap: RTL and testbench
=================================

Name: axis_fifo_wrap

Overview:
Synchronous single-clock AXI4-Stream FIFO buffering tdata plus all sideband fields (tstrb, tkeep, tlast, tid, tdest, tuser) between an upstream master (s_axis) and a downstream slave (m_axis). It is used as elastic storage inside stream pipelines. Output is first-word-fall-through: the head entry is presented on m_axis as soon as it is stored.

Parameters:
DEPTH, 32, number of entries; must be a power of 2, at least 2.
DATA_W, 8, tdata width in bits; must be a multiple of 8.
ID_W, 1, tid width.
DEST_W, 1, tdest width.
USER_W, 1, tuser width.
Derived, not overridable: DATA_BW = DATA_W/8, the strobe/keep width.
Derived, not overridable: entry width = DATA_W + 2*DATA_BW + 1 + ID_W + DEST_W + USER_W.

Ports:
axis_clk  in  1  single clock for both interfaces.
axis_rst  in  1  reset; asynchronous, active-high.
s_axis_tvalid  in  1  upstream data valid.
s_axis_tready  out  1  FIFO can accept a word.
s_axis_tdata  in  DATA_W  write data.
s_axis_tstrb  in  DATA_BW  byte strobes.
s_axis_tkeep  in  DATA_BW  byte keeps.
s_axis_tlast  in  1  end of packet.
s_axis_tid  in  ID_W  stream ID.
s_axis_tdest  in  DEST_W  routing destination.
s_axis_tuser  in  USER_W  user sideband.
m_axis_tvalid  out  1  head entry valid.
m_axis_tready  in  1  downstream accepts.
m_axis_tdata  out  DATA_W  head data.
m_axis_tstrb  out  DATA_BW  head strobes.
m_axis_tkeep  out  DATA_BW  head keeps.
m_axis_tlast  out  1  head tlast.
m_axis_tid  out  ID_W  head tid.
m_axis_tdest  out  DEST_W  head tdest.
m_axis_tuser  out  USER_W  head tuser.

Behaviour:
- One clock, asynchronous active-high reset. All state is updated on the rising edge of axis_clk.
- Storage:
  - DEPTH x entry-width memory.
  - Write pointer and read pointer are each log2(DEPTH)+1 bits; the MSB is a wrap bit.
  - empty = (wptr == rptr).
  - full = (address bits equal) and (wrap bits differ).
- Write: wr = s_axis_tvalid & s_axis_tready. On wr, store all s_axis fields at mem[wptr], then increment wptr modulo 2*DEPTH.
- Read: rd = m_axis_tvalid & m_axis_tready. On rd, increment rptr.
- s_axis_tready = !full. It is registered or derived from registered pointers and must not depend combinationally on m_axis_tready.
- m_axis_tvalid = !empty.
- m_axis_* fields = mem[rptr], driven combinationally (FWFT). Their values are don't-care while m_axis_tvalid = 0.
- Latency: a word written on edge N has m_axis_tvalid high after edge N, so it is consumable at edge N+1.
- Simultaneous wr and rd in one cycle: both pointers advance and the occupancy is unchanged. This is legal at any non-empty, non-full occupancy.
- When full: s_axis_tready = 0 and writes are ignored, even if m_axis_tready = 1 in the same cycle. tready rises the cycle after the first read.
- When empty: m_axis_tvalid = 0 and m_axis_tready is ignored.
- Pointers wrap around seamlessly. Ordering is strictly FIFO across wrap.
- AXI rules:
  - m_axis_* fields stay stable while m_axis_tvalid = 1 and m_axis_tready = 0.
  - Sideband fields are passed unmodified, with no packet awareness.
- Reset:
  - wptr = rptr = 0.
  - m_axis_tvalid = 0.
  - s_axis_tready = 0 while axis_rst is high, and 1 from the first edge after release.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored words immediately.

Test Plan:
1. Assert axis_rst asynchronously -> m_axis_tvalid = 0 immediately. After release -> s_axis_tready = 1, m_axis_tvalid = 0.
2. Write one word 0xA5 with tlast = 1, tid = 1, tuser = 1, while m_axis_tready = 0 -> m_axis_tvalid = 1 the next cycle with identical fields, held stable. Then assert m_axis_tready for 1 cycle -> m_axis_tvalid = 0.
3. With m_axis_tready = 0, write 0..31 on consecutive cycles -> s_axis_tready = 0 after the 32nd write, and a 33rd word (0xFF) is not accepted. Then assert m_axis_tready for 33 cycles -> 0..31 read out in order, then m_axis_tvalid = 0.
4. Keep m_axis_tready = 1 and stream words 0..63 at one per cycle -> all 64 words emerge in order with 1-cycle latency and s_axis_tready stays 1 throughout. This crosses the pointer wrap twice.
5. Fill to 32 entries, then assert s_axis_tvalid and m_axis_tready together -> the read succeeds, the write is refused that cycle and accepted the next cycle. Final read order is intact.
6. Write 5 words, then pulse axis_rst mid-stream -> m_axis_tvalid = 0 immediately. After release, writing 0x3C -> the next read returns 0x3C, not any stale entry.

Source files
------------

// File: rtl/axis_fifo_wrap_if.sv
// AXI4-Stream bundle used on both sides of axis_fifo_wrap.
// The master drives payload and tvalid, and the slave drives tready.
interface axis_fifo_wrap_if #(
  parameter int DATA_W = 8,
  parameter int ID_W   = 1,
  parameter int DEST_W = 1,
  parameter int USER_W = 1
);
  localparam int DATA_BW = DATA_W / 8;

  logic               tvalid;
  logic               tready;
  logic [DATA_W-1:0]  tdata;
  logic [DATA_BW-1:0] tstrb;
  logic [DATA_BW-1:0] tkeep;
  logic               tlast;
  logic [ID_W-1:0]    tid;
  logic [DEST_W-1:0]  tdest;
  logic [USER_W-1:0]  tuser;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/axis_fifo_wrap.sv
// Single-clock first-word-fall-through AXI4-Stream FIFO.
// The FIFO carries tdata and all sideband fields unmodified.
module axis_fifo_wrap #(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 8,
  parameter int ID_W   = 1,
  parameter int DEST_W = 1,
  parameter int USER_W = 1
) (
  input  logic             axis_clk,
  input  logic             axis_rst,
  axis_fifo_wrap_if.slave  s_axis,
  axis_fifo_wrap_if.master m_axis
);
  localparam int DATA_BW = DATA_W / 8;
  localparam int AW      = $clog2(DEPTH);
  localparam int ENTRY_W = DATA_W + 2*DATA_BW + 1 + ID_W + DEST_W + USER_W;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]        wptr_r;
  logic [AW:0]        rptr_r;
  logic [AW:0]        wptr_nxt_s;
  logic [AW:0]        rptr_nxt_s;
  logic               ready_r;
  logic               empty_s;
  logic               full_nxt_s;
  logic               wr_s;
  logic               rd_s;
  logic [ENTRY_W-1:0] mem_r [DEPTH];
  logic [ENTRY_W-1:0] wr_entry_s;
  logic [ENTRY_W-1:0] rd_entry_s;

  assign empty_s = (wptr_r == rptr_r);
  // ready_r is the registered !full and is held low in reset, so it gates writes.
  assign wr_s    = s_axis.tvalid & ready_r;
  assign rd_s    = m_axis.tready & ~empty_s;

  // Next-state pointers, used both for the update and for look-ahead full.
  always_comb begin
    wptr_nxt_s = wptr_r;
    rptr_nxt_s = rptr_r;
    if (wr_s) begin
      wptr_nxt_s = wptr_r + PTR_ONE;
    end else begin
      wptr_nxt_s = wptr_r;
    end
    if (rd_s) begin
      rptr_nxt_s = rptr_r + PTR_ONE;
    end else begin
      rptr_nxt_s = rptr_r;
    end
  end

  assign full_nxt_s = (wptr_nxt_s[AW-1:0] == rptr_nxt_s[AW-1:0]) &&
                      (wptr_nxt_s[AW] != rptr_nxt_s[AW]);

  // Pointer and ready state; reset drops every stored word at once.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      ready_r <= 1'b0;
    end else begin
      wptr_r  <= wptr_nxt_s;
      rptr_r  <= rptr_nxt_s;
      ready_r <= ~full_nxt_s;
    end
  end

  assign wr_entry_s = {s_axis.tdata, s_axis.tstrb, s_axis.tkeep, s_axis.tlast,
                       s_axis.tid, s_axis.tdest, s_axis.tuser};

  // Storage array; the contents are intentionally left unreset.
  always_ff @(posedge axis_clk) begin
    if (wr_s) begin
      mem_r[wptr_r[AW-1:0]] <= wr_entry_s;
    end
  end

  assign rd_entry_s = mem_r[rptr_r[AW-1:0]];

  assign s_axis.tready = ready_r;
  assign m_axis.tvalid = ~empty_s;
  assign {m_axis.tdata, m_axis.tstrb, m_axis.tkeep, m_axis.tlast,
          m_axis.tid, m_axis.tdest, m_axis.tuser} = rd_entry_s;
endmodule

// File: tb/tb_axis_fifo_wrap.sv
// Directed bench for axis_fifo_wrap.
// It covers reset, FWFT hold, fill/drain, streaming across wrap, full contention and mid-stream reset.
module tb_axis_fifo_wrap;
  logic axis_clk;
  logic axis_rst;
  int   n_vec;
  int   n_err;

  axis_fifo_wrap_if #(.DATA_W(8), .ID_W(1), .DEST_W(1), .USER_W(1)) s_if ();
  axis_fifo_wrap_if #(.DATA_W(8), .ID_W(1), .DEST_W(1), .USER_W(1)) m_if ();

  axis_fifo_wrap #(
    .DEPTH(32), .DATA_W(8), .ID_W(1), .DEST_W(1), .USER_W(1)
  ) dut (
    .axis_clk (axis_clk),
    .axis_rst (axis_rst),
    .s_axis   (s_if.slave),
    .m_axis   (m_if.master)
  );

  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  // The packed word is {data[7:0], strb, keep, last, id, dest, user}, which is 14 bits.
  typedef struct {
    logic        s_valid;
    logic [13:0] s_word;
    logic        m_ready;
    logic        exp_s_ready;
    logic        exp_m_valid;
    logic        chk_word;
    logic [13:0] exp_word;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [13:0] mkw(input logic [7:0] d, input logic strb, input logic keep,
                                      input logic last, input logic id, input logic dest,
                                      input logic user);
    return {d, strb, keep, last, id, dest, user};
  endfunction

  function automatic logic [13:0] head_word();
    return {m_if.tdata, m_if.tstrb, m_if.tkeep, m_if.tlast, m_if.tid, m_if.tdest, m_if.tuser};
  endfunction

  task automatic put(input logic v, input logic [13:0] w);
    s_if.tvalid = v;
    {s_if.tdata, s_if.tstrb, s_if.tkeep, s_if.tlast, s_if.tid, s_if.tdest, s_if.tuser} = w;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [13:0] wa;
    logic [13:0] wb;
    logic [13:0] wc;
    n_vec = 0;
    n_err = 0;
    axis_rst = 1'b0;
    m_if.tready = 1'b0;
    put(1'b0, 14'h0);

    wa = mkw(8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    wb = mkw(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    wc = mkw(8'h22, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    vecs[0] = '{1'b1, wa,    1'b0, 1'b1, 1'b0, 1'b0, 14'h0};
    vecs[1] = '{1'b0, 14'h0, 1'b0, 1'b1, 1'b1, 1'b1, wa};
    vecs[2] = '{1'b0, 14'h0, 1'b0, 1'b1, 1'b1, 1'b1, wa};
    vecs[3] = '{1'b0, 14'h0, 1'b1, 1'b1, 1'b1, 1'b1, wa};
    vecs[4] = '{1'b0, 14'h0, 1'b0, 1'b1, 1'b0, 1'b0, 14'h0};
    vecs[5] = '{1'b1, wb,    1'b1, 1'b1, 1'b0, 1'b0, 14'h0};
    vecs[6] = '{1'b1, wc,    1'b1, 1'b1, 1'b1, 1'b1, wb};
    vecs[7] = '{1'b0, 14'h0, 1'b0, 1'b1, 1'b1, 1'b1, wc};
    vecs[8] = '{1'b0, 14'h0, 1'b1, 1'b1, 1'b1, 1'b1, wc};
    vecs[9] = '{1'b0, 14'h0, 1'b0, 1'b1, 1'b0, 1'b0, 14'h0};

    // Asynchronous reset assertion, then release.
    #1 axis_rst = 1'b1;
    #1;
    chk("rst_m_valid", {31'd0, m_if.tvalid}, 32'd0);
    chk("rst_s_ready", {31'd0, s_if.tready}, 32'd0);
    repeat (2) @(negedge axis_clk);
    axis_rst = 1'b0;
    #1;
    chk("rel_s_ready_before_edge", {31'd0, s_if.tready}, 32'd0);

    // Table: single word hold and drain, empty read ignored, simultaneous wr+rd.
    for (int i = 0; i < 10; i++) begin
      @(negedge axis_clk);
      put(vecs[i].s_valid, vecs[i].s_word);
      m_if.tready = vecs[i].m_ready;
      chk($sformatf("tab%0d_s_ready", i), {31'd0, s_if.tready}, {31'd0, vecs[i].exp_s_ready});
      chk($sformatf("tab%0d_m_valid", i), {31'd0, m_if.tvalid}, {31'd0, vecs[i].exp_m_valid});
      if (vecs[i].chk_word) begin
        chk($sformatf("tab%0d_word", i), {18'd0, head_word()}, {18'd0, vecs[i].exp_word});
      end
    end

    // Fill to full, then refuse a 33rd word.
    for (int i = 0; i < 32; i++) begin
      @(negedge axis_clk);
      chk($sformatf("fill%0d_s_ready", i), {31'd0, s_if.tready}, 32'd1);
      put(1'b1, mkw(i[7:0], 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    @(negedge axis_clk);
    chk("full_s_ready", {31'd0, s_if.tready}, 32'd0);
    put(1'b1, mkw(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 33; i++) begin
      @(negedge axis_clk);
      put(1'b0, 14'h0);
      m_if.tready = 1'b1;
      if (i == 1) chk("ready_after_first_read", {31'd0, s_if.tready}, 32'd1);
      if (i < 32) begin
        chk($sformatf("drain%0d_valid", i), {31'd0, m_if.tvalid}, 32'd1);
        chk($sformatf("drain%0d_data", i), {24'd0, m_if.tdata}, i);
      end else begin
        chk("drain_end_valid", {31'd0, m_if.tvalid}, 32'd0);
      end
    end

    // Streaming with tready held high crosses the pointer wrap twice.
    for (int i = 0; i <= 64; i++) begin
      @(negedge axis_clk);
      m_if.tready = 1'b1;
      if (i < 64) begin
        put(1'b1, mkw(i[7:0], 1'b0, 1'b0, i[0], 1'b0, 1'b0, 1'b0));
        chk($sformatf("strm%0d_s_ready", i), {31'd0, s_if.tready}, 32'd1);
      end else begin
        put(1'b0, 14'h0);
      end
      if (i == 0) begin
        chk("strm0_m_valid", {31'd0, m_if.tvalid}, 32'd0);
      end else begin
        chk($sformatf("strm%0d_m_valid", i), {31'd0, m_if.tvalid}, 32'd1);
        chk($sformatf("strm%0d_data", i), {24'd0, m_if.tdata}, i - 1);
      end
    end
    @(negedge axis_clk);
    m_if.tready = 1'b0;
    chk("strm_end_valid", {31'd0, m_if.tvalid}, 32'd0);

    // Full with simultaneous write and read: the write is refused, then taken next cycle.
    for (int i = 0; i < 32; i++) begin
      @(negedge axis_clk);
      put(1'b1, mkw(8'h40 + i[7:0], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    @(negedge axis_clk);
    put(1'b1, mkw(8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    m_if.tready = 1'b1;
    chk("cont_s_ready_full", {31'd0, s_if.tready}, 32'd0);
    chk("cont_head0", {24'd0, m_if.tdata}, 32'h40);
    @(negedge axis_clk);
    m_if.tready = 1'b0;
    chk("cont_s_ready_after_rd", {31'd0, s_if.tready}, 32'd1);
    chk("cont_head1", {24'd0, m_if.tdata}, 32'h41);
    @(negedge axis_clk);
    put(1'b0, 14'h0);
    chk("cont_s_ready_refull", {31'd0, s_if.tready}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      if (i > 0) @(negedge axis_clk);
      m_if.tready = 1'b1;
      chk($sformatf("cont_drain%0d", i), {24'd0, m_if.tdata},
          (i < 31) ? (32'h41 + i) : 32'h80);
    end
    @(negedge axis_clk);
    chk("cont_end_valid", {31'd0, m_if.tvalid}, 32'd0);
    m_if.tready = 1'b0;

    // A reset mid-stream discards stored words.
    for (int i = 0; i < 5; i++) begin
      @(negedge axis_clk);
      put(1'b1, mkw(8'h10 + i[7:0], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    @(negedge axis_clk);
    put(1'b0, 14'h0);
    chk("pre_rst_valid", {31'd0, m_if.tvalid}, 32'd1);
    #2 axis_rst = 1'b1;
    #1;
    chk("mid_rst_m_valid", {31'd0, m_if.tvalid}, 32'd0);
    chk("mid_rst_s_ready", {31'd0, s_if.tready}, 32'd0);
    @(negedge axis_clk);
    axis_rst = 1'b0;
    @(negedge axis_clk);
    chk("post_rst_s_ready", {31'd0, s_if.tready}, 32'd1);
    chk("post_rst_m_valid", {31'd0, m_if.tvalid}, 32'd0);
    put(1'b1, mkw(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge axis_clk);
    put(1'b0, 14'h0);
    m_if.tready = 1'b1;
    chk("post_rst_valid", {31'd0, m_if.tvalid}, 32'd1);
    chk("post_rst_data", {24'd0, m_if.tdata}, 32'h3C);
    @(negedge axis_clk);
    m_if.tready = 1'b0;
    chk("post_rst_empty", {31'd0, m_if.tvalid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
